// File: rtl/alu_pkg.sv
// alu_seq shared types: operation codes and FSM states.
// Imported by the ALU core and the sequencing top.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_ROR  = 3'b001,
    OP_ROL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_ADD  = 3'b101,
    OP_SUB  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_rot(op_e op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: single-cycle ops plus ZF/CF/NF generation.
// Rotates pass A through; the iterative rotate lives in alu_seq.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic             zf_o,
  output logic             cf_o,
  output logic             nf_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Result and carry/borrow select by op
  always_comb begin
    r_o  = a_i;
    cf_o = 1'b0;
    unique case (op_i)
      OP_XOR:  r_o = a_i ^ b_i;
      OP_AND:  r_o = a_i & b_i;
      OP_OR:   r_o = a_i | b_i;
      OP_ADD: begin
        r_o  = sum[WIDTH-1:0];
        cf_o = sum[WIDTH];
      end
      OP_SUB: begin
        r_o  = diff[WIDTH-1:0];
        cf_o = diff[WIDTH];
      end
      OP_ROR,
      OP_ROL,
      OP_PASS: r_o = a_i;
      default: r_o = a_i;
    endcase
  end

  assign zf_o = (r_o == '0);
  assign nf_o = r_o[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: valid/ready in, registered result and flags out.
// Rotates step one bit per cycle under an IDLE/BUSY/DONE FSM.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 5,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             ZF,
  output logic             CF,
  output logic             NF
);

  if (WIDTH < 2) begin : g_width_chk
    $error("alu_seq: WIDTH must be >= 2");
  end

  localparam logic [WIDTH-1:0] WL = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic             nf_q, nf_d;

  logic [CNT_W-1:0] amt;
  logic             rot_go;
  logic [WIDTH-1:0] rot_step;
  logic             last_step;

  op_e              core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_r;
  logic             core_zf;
  logic             core_cf;
  logic             core_nf;

  assign amt       = CNT_W'(B % WL);
  assign rot_go    = is_rot(op) && (amt != '0);
  assign last_step = (cnt_q == CNT_W'(1));

  // dir_q=1 rotates left, else right
  assign rot_step = dir_q
    ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
    : {work_q[0], work_q[WIDTH-1:1]};

  // Final rotate value goes through PASS for flags
  assign core_op = (state_q == BUSY) ? OP_PASS : op;
  assign core_a  = (state_q == BUSY) ? rot_step : A;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i(core_op),
    .a_i (core_a),
    .b_i (B),
    .r_o (core_r),
    .zf_o(core_zf),
    .cf_o(core_cf),
    .nf_o(core_nf)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = rot_go ? BUSY : DONE;
      BUSY: if (last_step) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: latch on transfer, step in BUSY
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    r_d    = r_q;
    zf_d   = zf_q;
    cf_d   = cf_q;
    nf_d   = nf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dir_d = (op == OP_ROL);
          if (rot_go) begin
            work_d = A;
            cnt_d  = amt;
          end else begin
            r_d  = core_r;
            zf_d = core_zf;
            cf_d = core_cf;
            nf_d = core_nf;
          end
        end
      end
      BUSY: begin
        work_d = rot_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (last_step) begin
          r_d  = core_r;
          zf_d = core_zf;
          cf_d = core_cf;
          nf_d = core_nf;
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      r_q    <= '0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      nf_q   <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      r_q    <= r_d;
      zf_q   <= zf_d;
      cf_q   <= cf_d;
      nf_q   <= nf_d;
    end
  end

  assign R  = r_q;
  assign ZF = zf_q;
  assign CF = cf_q;
  assign NF = nf_q;

endmodule
